// File: rtl/hd_encode_classify.sv
// Hyperdimensional encoder (signed per-lane accumulation over ENC_BEATS beats) plus a class memory that is
// swept row by row after each encode. Define HD_ENC_SATURATE_EN for saturating accumulators (default wraps).
module hd_encode_classify #(
    parameter int M_SIZE         = 16,
    parameter int FTWIDTH        = 8,
    parameter int DIM_WIDTH      = 16,
    parameter int ENC_BEATS      = 32,
    parameter int CLASS_NUM      = 26,
    parameter int CLA_ADDR_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        class_write,
    input  logic [FTWIDTH-1:0]          class_in,
    output logic                        write_done,
    input  logic                        enc_valid,
    input  logic [2*M_SIZE-1:0]         projections,
    input  logic [M_SIZE*FTWIDTH-1:0]   features,
    output logic [M_SIZE*DIM_WIDTH-1:0] enc_out,
    output logic                        enc_done,
    output logic [CLA_ADDR_WIDTH-1:0]   class_addr,
    output logic [M_SIZE*FTWIDTH-1:0]   class_out,
    output logic                        class_valid,
    output logic                        read_done
);

    localparam int BYTE_W = (M_SIZE > 1) ? $clog2(M_SIZE) : 1;
    localparam int BEAT_W = (ENC_BEATS > 1) ? $clog2(ENC_BEATS) : 1;
    localparam logic [BYTE_W-1:0]         LAST_BYTE = BYTE_W'(M_SIZE - 1);
    localparam logic [CLA_ADDR_WIDTH-1:0] LAST_ROW  = CLA_ADDR_WIDTH'(CLASS_NUM - 1);
    localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'(ENC_BEATS - 1);

`ifdef HD_ENC_SATURATE_EN
    localparam logic signed [DIM_WIDTH+1:0] SAT_MAX = {3'b000, {(DIM_WIDTH-1){1'b1}}};
    localparam logic signed [DIM_WIDTH+1:0] SAT_MIN = {3'b111, {(DIM_WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ
    } ctrl_state_t;

    // ---------------- class memory write side ----------------
    logic [M_SIZE-1:0][FTWIDTH-1:0] mem [CLASS_NUM];
    logic [BYTE_W-1:0]              byte_ptr;
    logic [CLA_ADDR_WIDTH-1:0]      row_ptr;
    logic                           write_en;

    assign write_en = class_write && !write_done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_ptr   <= '0;
            row_ptr    <= '0;
            write_done <= 1'b0;
        end else if (write_en) begin
            if (byte_ptr == LAST_BYTE) begin
                byte_ptr <= '0;
                if (row_ptr == LAST_ROW) write_done <= 1'b1;
                else                     row_ptr    <= row_ptr + 1'b1;
            end else begin
                byte_ptr <= byte_ptr + 1'b1;
            end
        end
    end

    // NOTE: the memory array and its read register are deliberately left without reset so they map onto RAM.
    always_ff @(posedge clk) begin
        if (write_en) mem[row_ptr][byte_ptr] <= class_in;
        class_out <= mem[class_addr];
    end

    // ---------------- encoder ----------------
    logic [M_SIZE-1:0][DIM_WIDTH-1:0] acc, acc_next;
    logic [BEAT_W-1:0]                beat_cnt;
    logic                             beat_en;
    logic                             first_beat;

    assign beat_en    = enc_valid && write_done;
    assign first_beat = (beat_cnt == '0);

    function automatic logic [DIM_WIDTH-1:0] lane_step(input logic [DIM_WIDTH-1:0] base,
                                                       input logic [FTWIDTH-1:0]   feat,
                                                       input logic                 add);
`ifdef HD_ENC_SATURATE_EN
        logic signed [DIM_WIDTH+1:0] base_x, feat_x, sum;
        base_x = signed'({{2{base[DIM_WIDTH-1]}}, base});
        feat_x = signed'({{(DIM_WIDTH+2-FTWIDTH){1'b0}}, feat});
        sum    = add ? base_x + feat_x : base_x - feat_x;
        if (sum > SAT_MAX) return {1'b0, {(DIM_WIDTH-1){1'b1}}};
        if (sum < SAT_MIN) return {1'b1, {(DIM_WIDTH-1){1'b0}}};
        return sum[DIM_WIDTH-1:0];
`else
        logic [DIM_WIDTH-1:0] feat_x;
        feat_x = {{(DIM_WIDTH-FTWIDTH){1'b0}}, feat};
        return add ? base + feat_x : base - feat_x;
`endif
    endfunction

    // NOTE: acc_next gets a full default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        acc_next = acc;
        for (int m = 0; m < M_SIZE; m++) begin
            if (projections[M_SIZE+m])
                acc_next[m] = lane_step(first_beat ? '0 : acc[m],
                                        features[m*FTWIDTH +: FTWIDTH], projections[m]);
            else if (first_beat)
                acc_next[m] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc      <= '0;
            beat_cnt <= '0;
            enc_done <= 1'b0;
        end else begin
            enc_done <= 1'b0;
            if (beat_en) begin
                acc <= acc_next;
                if (beat_cnt == LAST_BEAT) begin
                    beat_cnt <= '0;
                    enc_done <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    assign enc_out = acc;

    // ---------------- read controller ----------------
    ctrl_state_t state;
    logic        pending;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            class_addr  <= '0;
            class_valid <= 1'b0;
            read_done   <= 1'b0;
            pending     <= 1'b0;
        end else begin
            class_valid <= 1'b0;
            read_done   <= 1'b0;
            case (state)
                ST_IDLE: if (write_done) state <= ST_WAIT;
                ST_WAIT: if (enc_done) begin
                    state      <= ST_READ;
                    class_addr <= '0;
                end
                ST_READ: begin
                    // Data for the address presented now appears on class_out next cycle.
                    class_valid <= 1'b1;
                    if (class_addr == LAST_ROW) begin
                        read_done  <= 1'b1;
                        class_addr <= '0;
                        pending    <= 1'b0;
                        if (!(pending || enc_done)) state <= ST_WAIT;
                    end else begin
                        class_addr <= class_addr + 1'b1;
                        if (enc_done) pending <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hd_encode_classify.sv
// Randomized self-checking bench: three instances (32-, 4- and 256-beat encoders) share one class-memory
// write stream; a queue-free arithmetic model predicts accumulators, memory rows and read sweeps.
module tb_hd_encode_classify;

    localparam int NCLS  = 26;
    localparam int TOTAL = 16 * NCLS;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic         class_write = 1'b0;
    logic [7:0]   class_in = '0;

    logic         enc_valid   [3];
    logic [31:0]  proj        [3];
    logic [127:0] feat        [3];
    logic         write_done  [3];
    logic [255:0] enc_out     [3];
    logic         enc_done    [3];
    logic [4:0]   class_addr  [3];
    logic [127:0] class_out   [3];
    logic         class_valid [3];
    logic         read_done   [3];

    hd_encode_classify #(.ENC_BEATS(32)) dut (
        .clk(clk), .reset(reset), .class_write(class_write), .class_in(class_in),
        .write_done(write_done[0]), .enc_valid(enc_valid[0]), .projections(proj[0]),
        .features(feat[0]), .enc_out(enc_out[0]), .enc_done(enc_done[0]),
        .class_addr(class_addr[0]), .class_out(class_out[0]), .class_valid(class_valid[0]),
        .read_done(read_done[0]));

    hd_encode_classify #(.ENC_BEATS(4)) dut_pend (
        .clk(clk), .reset(reset), .class_write(class_write), .class_in(class_in),
        .write_done(write_done[1]), .enc_valid(enc_valid[1]), .projections(proj[1]),
        .features(feat[1]), .enc_out(enc_out[1]), .enc_done(enc_done[1]),
        .class_addr(class_addr[1]), .class_out(class_out[1]), .class_valid(class_valid[1]),
        .read_done(read_done[1]));

    hd_encode_classify #(.ENC_BEATS(256)) dut_sat (
        .clk(clk), .reset(reset), .class_write(class_write), .class_in(class_in),
        .write_done(write_done[2]), .enc_valid(enc_valid[2]), .projections(proj[2]),
        .features(feat[2]), .enc_out(enc_out[2]), .enc_done(enc_done[2]),
        .class_addr(class_addr[2]), .class_out(class_out[2]), .class_valid(class_valid[2]),
        .read_done(read_done[2]));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int enc_done_cnt [3] = '{0, 0, 0};
    int read_done_cnt[3] = '{0, 0, 0};
    int pend_valid_q[$];
    int pend_done_q[$];
    logic [7:0] ref_mem [TOTAL];
    int model [3][16];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ref_row(input int r);
        logic [127:0] row;
        for (int k = 0; k < 16; k++) row[8*k +: 8] = ref_mem[16*r + k];
        return row;
    endfunction

    function automatic int beats_of(input int which);
        return (which == 0) ? 32 : (which == 1) ? 4 : 256;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Per-instance sweep monitor: row order, row data and read_done position.
    for (genvar g = 0; g < 3; g++) begin : g_mon
        int         exp_row = 0;
        logic [4:0] prev_addr = '0;
        always @(negedge clk) begin
            if (!reset) begin
                exp_row   = 0;
                prev_addr = '0;
            end else begin
                if (enc_done[g])  enc_done_cnt[g]++;
                if (read_done[g]) begin
                    read_done_cnt[g]++;
                    if (g == 1) pend_done_q.push_back(cyc);
                end
                if (class_valid[g]) begin
                    if (g == 1) pend_valid_q.push_back(cyc);
                    check($sformatf("addr_seq%0d", g), 256'(prev_addr), 256'(exp_row));
                    check($sformatf("row_data%0d", g), 256'(class_out[g]), 256'(ref_row(exp_row)));
                    check($sformatf("read_done_pos%0d", g), 256'(read_done[g]), 256'(exp_row == NCLS - 1));
                    exp_row = (exp_row + 1) % NCLS;
                end
                prev_addr = class_addr[g];
            end
        end
    end

    // Drives one full encode on instance `which`; checks enc_done and enc_out right after the last beat.
    task automatic do_encode(input int which, input int mode, input bit gaps);
        logic [127:0] f;
        logic [31:0]  p;
        logic [255:0] ev;
        int           base, t;
        for (int b = 0; b < beats_of(which); b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    enc_valid[which] = 1'b0;
                    feat[which] = {$urandom, $urandom, $urandom, $urandom};
                    proj[which] = $urandom;
                    tick(1);
                end
            end
            case (mode)
                0: begin f = {16{8'd1}};   p = 32'hFFFF_FFFF; end
                1: begin f = {16{8'd3}};   p = 32'h0000_FFFF; end
                2: begin f = {16{8'd3}};   p = 32'hFFFF_0000; end
                4: begin f = {16{8'hFF}};  p = 32'hFFFF_FFFF; end
                5: begin f = {16{8'hFF}};  p = 32'hFFFF_0000; end
                default: begin f = {$urandom, $urandom, $urandom, $urandom}; p = $urandom; end
            endcase
            for (int m = 0; m < 16; m++) begin
                base = (b == 0) ? 0 : model[which][m];
                if (p[16+m]) base = p[m] ? base + int'(f[8*m +: 8]) : base - int'(f[8*m +: 8]);
`ifdef HD_ENC_SATURATE_EN
                if (base > 32767)  base = 32767;
                if (base < -32768) base = -32768;
`endif
                model[which][m] = base;
            end
            enc_valid[which] = 1'b1;
            feat[which] = f;
            proj[which] = p;
            tick(1);
        end
        enc_valid[which] = 1'b0;
        for (int m = 0; m < 16; m++) begin
            t = model[which][m];
            ev[16*m +: 16] = t[15:0];
        end
        check($sformatf("enc_done%0d", which), 256'(enc_done[which]), 256'(1));
        check($sformatf("enc_out%0d_m%0d", which, mode), enc_out[which], ev);
    endtask

    task automatic pend_run(input int n);
        int d0;
        pend_valid_q.delete();
        pend_done_q.delete();
        d0 = enc_done_cnt[1];
        for (int i = 0; i < n; i++) do_encode(1, 3, 1'b0);
        tick(70);
        check("pend_enc_done_cnt", 256'(enc_done_cnt[1] - d0), 256'(n));
        check("pend_valid_cycles", 256'(pend_valid_q.size()), 256'(2 * NCLS));
        check("pend_read_dones", 256'(pend_done_q.size()), 256'(2));
        if (pend_valid_q.size() == 2 * NCLS && pend_done_q.size() == 2) begin
            check("pend_contiguous", 256'(pend_valid_q[2*NCLS-1] - pend_valid_q[0]), 256'(2 * NCLS - 1));
            check("pend_done_first", 256'(pend_done_q[0]), 256'(pend_valid_q[NCLS-1]));
            check("pend_done_second", 256'(pend_done_q[1]), 256'(pend_valid_q[2*NCLS-1]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ed, rd;
        int modes[5] = '{0, 1, 2, 3, 3};
        for (int i = 0; i < 3; i++) begin
            enc_valid[i] = 1'b0;
            feat[i] = '0;
            proj[i] = '0;
        end

        tick(3);
        check("rst_write_done", 256'(write_done[0]), 256'(0));
        check("rst_enc_out", enc_out[0], 256'(0));
        check("rst_enc_done", 256'(enc_done[0]), 256'(0));
        check("rst_class_addr", 256'(class_addr[0]), 256'(0));
        check("rst_class_valid", 256'(class_valid[0]), 256'(0));
        check("rst_read_done", 256'(read_done[0]), 256'(0));
        reset = 1'b1;

        // Beats before the memory is full must be ignored.
        for (int i = 0; i < 40; i++) begin
            enc_valid[0] = 1'b1;
            feat[0] = {16{8'd1}};
            proj[0] = 32'hFFFF_FFFF;
            tick(1);
        end
        enc_valid[0] = 1'b0;
        tick(2);
        check("early_beats_no_done", 256'(enc_done_cnt[0]), 256'(0));
        check("early_beats_enc_out", enc_out[0], 256'(0));

        for (int i = 0; i < TOTAL; i++) begin
            repeat ($urandom_range(0, 1)) tick(1);
            class_write = 1'b1;
            class_in    = 8'($urandom);
            ref_mem[i]  = class_in;
            tick(1);
            class_write = 1'b0;
            if (i == TOTAL - 2) check("write_done_early", 256'(write_done[0]), 256'(0));
        end
        for (int g = 0; g < 3; g++) check($sformatf("write_done%0d", g), 256'(write_done[g]), 256'(1));

        // Writes after the memory is full must not disturb any row.
        for (int i = 0; i < 5; i++) begin
            class_write = 1'b1;
            class_in    = ~ref_mem[i];
            tick(1);
        end
        class_write = 1'b0;
        check("write_done_sticky", 256'(write_done[0]), 256'(1));

        for (int k = 0; k < 5; k++) begin
            do_encode(0, modes[k], 1'b1);
            tick(40);
            check("main_enc_done_cnt", 256'(enc_done_cnt[0]), 256'(k + 1));
            check("main_read_done_cnt", 256'(read_done_cnt[0]), 256'(k + 1));
            check("main_addr_idle", 256'(class_addr[0]), 256'(0));
        end

        pend_run(2);
        pend_run(3);

        do_encode(2, 4, 1'b0);
        do_encode(2, 5, 1'b0);
        do_encode(2, 3, 1'b1);
        tick(40);

        // Reset in the middle of an encode and a read sweep abandons both.
        for (int i = 0; i < 16; i++) begin
            enc_valid[0] = 1'b1;
            feat[0] = {$urandom, $urandom, $urandom, $urandom};
            proj[0] = $urandom;
            tick(1);
        end
        enc_valid[0] = 1'b0;
        do_encode(1, 3, 1'b0);
        tick(5);
        ed = enc_done_cnt[0];
        rd = read_done_cnt[1];
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        check("midrst_write_done", 256'(write_done[0]), 256'(0));
        check("midrst_enc_out", enc_out[0], 256'(0));
        check("midrst_class_valid", 256'(class_valid[1]), 256'(0));
        check("midrst_class_addr", 256'(class_addr[1]), 256'(0));
        for (int i = 0; i < 20; i++) begin
            enc_valid[0] = 1'b1;
            tick(1);
        end
        enc_valid[0] = 1'b0;
        tick(40);
        check("midrst_no_enc_done", 256'(enc_done_cnt[0]), 256'(ed));
        check("midrst_no_read_done", 256'(read_done_cnt[1]), 256'(rd));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
